// File: rtl/l2_arbiter_if.sv
// l2_arbiter_if: request/ack/select bundle between the I/D caches, the L2
// wishbone port and the L2 arbiter.
//   i_req, d_req     : cache miss requests (CYC||STB toward L2)
//   mem_ack, mem_rty : L2 wishbone ACK / RTY
//   cache_sel        : L2 master-mux select, 1 = I-cache, 0 = D-cache
//   i_ack, d_ack     : mem_ack steered to the granted cache
//   busy             : a grant is active
// master = cache/L2 side driving requests and acks, slave = the arbiter.
interface l2_arbiter_if;
    logic i_req;
    logic d_req;
    logic mem_ack;
    logic mem_rty;
    logic cache_sel;
    logic i_ack;
    logic d_ack;
    logic busy;

    modport master (
        output i_req, d_req, mem_ack, mem_rty,
        input  cache_sel, i_ack, d_ack, busy
    );

    modport slave (
        input  i_req, d_req, mem_ack, mem_rty,
        output cache_sel, i_ack, d_ack, busy
    );
endinterface

// File: rtl/l2_arbiter.sv
// l2_arbiter: two-requester (I-cache / D-cache) arbiter for the shared L2
// wishbone port. D wins ties until I has waited through STARVE_LIMIT D grants,
// then I is forced ahead. One-cycle grant latency, one IDLE cycle between
// grants.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : l2_arbiter_if.slave (requests, L2 ack/rty, select, acks, busy)
module l2_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    l2_arbiter_if.slave       bus
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_cache_sel;
    logic             r_busy;

    logic w_pick_i;
    logic w_done_i;
    logic w_done_d;

    // I wins when alone, or when it has been starved long enough
    assign w_pick_i = bus.i_req && (!bus.d_req || (r_starve_cnt == STARVE_MAX));

    // Grant ends on completion, or when the owner withdraws its request
    assign w_done_i = bus.mem_ack || !bus.i_req;
    assign w_done_d = bus.mem_ack || !bus.d_req;

    // Arbitration state, starvation counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
            r_cache_sel  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_i) begin
                        r_state      <= S_GRANT_I;
                        r_starve_cnt <= '0;
                        r_cache_sel  <= 1'b1;
                        r_busy       <= 1'b1;
                    end else if (bus.d_req) begin
                        r_state     <= S_GRANT_D;
                        r_cache_sel <= 1'b0;
                        r_busy      <= 1'b1;
                        // Count D grants taken while I was waiting
                        if (bus.i_req && (r_starve_cnt != STARVE_MAX))
                            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                    end
                end
                S_GRANT_I: begin
                    if (w_done_i) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (bus.mem_rty) begin
                        // Retry is reissued on the same grant
                        r_state <= S_GRANT_I;
                    end
                end
                S_GRANT_D: begin
                    if (w_done_d) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (bus.mem_rty) begin
                        r_state <= S_GRANT_D;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cache_sel = r_cache_sel;
    assign bus.busy      = r_busy;

    // Ack steering; an ack coinciding with reset belongs to an aborted grant
    assign bus.i_ack = !rst && bus.mem_ack && (r_state == S_GRANT_I);
    assign bus.d_ack = !rst && bus.mem_ack && (r_state == S_GRANT_D);

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed vector table, a starvation-order sequence and a
// randomized run against a grant-level reference model.
module tb_l2_arbiter;

    localparam int unsigned LIMIT = 4;
    localparam int NV = 30;
    localparam int NRAND = 2000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_arbiter_if bus();

    l2_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // {rst, i_req, d_req, mem_ack, mem_rty} -> {cache_sel, busy, i_ack, d_ack}
    typedef struct packed {
        logic rst;
        logic i_req;
        logic d_req;
        logic ack;
        logic rty;
        logic e_sel;
        logic e_busy;
        logic e_iack;
        logic e_dack;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic i, input logic d,
                         input logic a, input logic y);
        rst         = r;
        bus.i_req   = i;
        bus.d_req   = d;
        bus.mem_ack = a;
        bus.mem_rty = y;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset check and single I transaction (ack at cycle 3)
        tbl[0]  = vec_t'(9'b10010_0000);
        tbl[1]  = vec_t'(9'b01000_0000);
        tbl[2]  = vec_t'(9'b01000_1100);
        tbl[3]  = vec_t'(9'b01000_1100);
        tbl[4]  = vec_t'(9'b01010_1110);
        tbl[5]  = vec_t'(9'b00000_1000);
        // I grant aborted, then stray ack in IDLE
        tbl[6]  = vec_t'(9'b01000_1000);
        tbl[7]  = vec_t'(9'b01000_1100);
        tbl[8]  = vec_t'(9'b00000_1100);
        tbl[9]  = vec_t'(9'b00010_1000);
        // D grant with two retries then ack
        tbl[10] = vec_t'(9'b00100_1000);
        tbl[11] = vec_t'(9'b00101_0100);
        tbl[12] = vec_t'(9'b00100_0100);
        tbl[13] = vec_t'(9'b00101_0100);
        tbl[14] = vec_t'(9'b00110_0101);
        tbl[15] = vec_t'(9'b00000_0000);
        // D acked while I pending, then I granted after one IDLE cycle
        tbl[16] = vec_t'(9'b00100_0000);
        tbl[17] = vec_t'(9'b01100_0100);
        tbl[18] = vec_t'(9'b01010_0101);
        tbl[19] = vec_t'(9'b01000_0000);
        tbl[20] = vec_t'(9'b01000_1100);
        tbl[21] = vec_t'(9'b01010_1110);
        tbl[22] = vec_t'(9'b00000_1000);
        // reset in cycle 2 of a D grant with ack high, I pending
        tbl[23] = vec_t'(9'b00100_1000);
        tbl[24] = vec_t'(9'b01100_0100);
        tbl[25] = vec_t'(9'b11110_0100);
        tbl[26] = vec_t'(9'b01000_0000);
        tbl[27] = vec_t'(9'b01000_1100);
        tbl[28] = vec_t'(9'b01010_1110);
        tbl[29] = vec_t'(9'b00000_1000);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        for (int k = 0; k < NV; k++) begin
            vec_t v;
            v = tbl[k];
            drive(v.rst, v.i_req, v.d_req, v.ack, v.rty);
            #1;
            chk($sformatf("vec%0d.cache_sel", k), bus.cache_sel, v.e_sel);
            chk($sformatf("vec%0d.busy", k), bus.busy, v.e_busy);
            chk($sformatf("vec%0d.i_ack", k), bus.i_ack, v.e_iack);
            chk($sformatf("vec%0d.d_ack", k), bus.d_ack, v.e_dack);
            tick();
        end

        // both requests held: D,D,D,D,I,D,D,D,D,I, each acked in grant cycle 2
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int g = 0; g < 10; g++) begin
            int w;
            logic exp_i;
            exp_i = ((g % 5) == 4);
            w = 0;
            while (bus.busy !== 1'b1 && w < 6) begin
                tick();
                w++;
            end
            chk($sformatf("starve.g%0d.busy", g), bus.busy, 1'b1);
            chk($sformatf("starve.g%0d.cache_sel", g), bus.cache_sel, exp_i);
            tick();
            bus.mem_ack = 1'b1;
            #1;
            chk($sformatf("starve.g%0d.i_ack", g), bus.i_ack, exp_i);
            chk($sformatf("starve.g%0d.d_ack", g), bus.d_ack, !exp_i);
            tick();
            bus.mem_ack = 1'b0;
        end

        // randomized run against a grant-level model
        begin
            int   owner;   // 0 = nobody, 1 = I, 2 = D
            int   waits;   // D grants I has sat through since its last grant
            logic m_sel;
            owner = 0;
            waits = 0;
            m_sel = 1'b0;
            for (int n = 0; n < NRAND; n++) begin
                logic r, i, d, a, y;
                r = (n == 0) || ($urandom_range(63) == 0);
                i = ($urandom_range(3) != 0);
                d = ($urandom_range(3) != 0);
                a = ($urandom_range(9) < 3);
                y = ($urandom_range(9) < 2);
                drive(r, i, d, a, y);
                #1;
                if (n > 0) begin
                    chk($sformatf("rand%0d.cache_sel", n), bus.cache_sel, m_sel);
                    chk($sformatf("rand%0d.busy", n), bus.busy, owner != 0);
                    chk($sformatf("rand%0d.i_ack", n), bus.i_ack, !r && a && owner == 1);
                    chk($sformatf("rand%0d.d_ack", n), bus.d_ack, !r && a && owner == 2);
                end
                if (r) begin
                    owner = 0;
                    waits = 0;
                    m_sel = 1'b0;
                end else if (owner == 0) begin
                    if (i && (!d || waits >= int'(LIMIT))) begin
                        owner = 1;
                        waits = 0;
                        m_sel = 1'b1;
                    end else if (d) begin
                        owner = 2;
                        m_sel = 1'b0;
                        if (i) waits = (waits + 1 > int'(LIMIT)) ? int'(LIMIT) : waits + 1;
                    end
                end else if (a || (owner == 1 ? !i : !d)) begin
                    owner = 0;
                end
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive D grants issued while I waits before I is forced ahead (legal range 1..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port i_req, input, 1, I-cache miss request (its CYC||STB toward L2).
REQ-005 SHALL have port d_req, input, 1, D-cache miss/writeback request (its CYC||STB toward L2).
REQ-006 SHALL have port mem_ack, input, 1, L2 wishbone ACK.
REQ-007 SHALL have port mem_rty, input, 1, L2 wishbone RTY.
REQ-008 SHALL have port cache_sel, output, 1, L2 master-mux select: 1 = I-cache, 0 = D-cache.
REQ-009 SHALL have ports i_ack and d_ack, output, 1 each, mem_ack steered to the granted cache only.
REQ-010 SHALL have port busy, output, 1, high while any grant is active.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT_I and GRANT_D.
REQ-012 In IDLE with only i_req, SHALL enter GRANT_I on the next edge; with only d_req, SHALL enter GRANT_D; with neither, SHALL stay in IDLE.
REQ-013 In IDLE with both requests, SHALL enter GRANT_I if starve_cnt == STARVE_LIMIT, else GRANT_D (D priority by default).
REQ-014 starve_cnt (3 bits) SHALL increment, saturating at STARVE_LIMIT, on each IDLE->GRANT_D transition while i_req is high.
REQ-015 starve_cnt SHALL clear on each IDLE->GRANT_I transition.
REQ-016 starve_cnt SHALL hold otherwise.
REQ-017 Grant latency SHALL be exactly one cycle: request sampled in IDLE at edge N gives a grant from cycle N+1; there is no combinational request-to-grant path.
REQ-018 In GRANT_x, SHALL stay granted until mem_ack, then return to IDLE on that edge; one IDLE cycle always separates consecutive grants.
REQ-019 In GRANT_x with mem_rty and no mem_ack, SHALL keep the grant (the requester retries on the same grant).
REQ-020 If the granted requester deasserts its request without mem_ack (abort), SHALL return to IDLE on the next edge.
REQ-021 mem_ack together with the granted request dropping SHALL be treated as a normal completion, identical to REQ-018.
REQ-022 cache_sel SHALL be 1 in GRANT_I and 0 in GRANT_D.
REQ-023 In IDLE, cache_sel SHALL hold its last granted value so the L2 mux does not toggle without a grant.
REQ-024 i_ack SHALL equal mem_ack && state==GRANT_I.
REQ-025 d_ack SHALL equal mem_ack && state==GRANT_D.
REQ-026 mem_ack in IDLE SHALL be dropped (neither i_ack nor d_ack asserted).
REQ-027 busy SHALL be high in GRANT_I or GRANT_D and low in IDLE.
REQ-028 cache_sel, busy and state SHALL be registered; i_ack and d_ack SHALL be combinational from the registered state and mem_ack.

Reset
REQ-029 On rst at an edge, SHALL go to state IDLE, starve_cnt=0, cache_sel=0.
REQ-030 Outputs during and after reset SHALL be: busy=0, and i_ack=0 and d_ack=0 regardless of mem_ack.
REQ-031 rst mid-grant SHALL abort the transaction; no ack is routed in the cycle after reset.
REQ-032 Requests present when rst deasserts SHALL be arbitrated normally one cycle later.

Verification
REQ-033 i_req alone at cycle 0, mem_ack at cycle 3 -> cache_sel=1 and busy=1 for cycles 1-3, i_ack=1 only at cycle 3, IDLE at cycle 4.
REQ-034 i_req and d_req held high, STARVE_LIMIT=4, every transaction acked after 2 cycles -> grant order D,D,D,D,I,D,D,D,D,I with starve_cnt cleared after each I grant.
REQ-035 GRANT_D with mem_rty pulsed twice, then mem_ack -> grant held throughout, d_ack exactly once, i_ack never asserted.
REQ-036 GRANT_I, then i_req drops with no ack -> IDLE next edge, busy=0, cache_sel stays 1; a stray mem_ack in IDLE routes to neither ack output.
REQ-037 rst asserted in cycle 2 of GRANT_D, with mem_ack high in the same cycle -> IDLE, cache_sel=0, d_ack=0 next cycle; pending i_req granted one cycle after rst deasserts.
REQ-038 mem_ack in GRANT_D while i_req is pending -> d_ack once, one IDLE cycle, then GRANT_I with cache_sel=1.
